fwd_unit: RTL and testbench
===========================

# fwd_unit

Forwarding and load-use hazard controller for the five-stage pipeline. It tracks destination registers of instructions in flight through EX, MEM and WB, and produces the registered 2-bit select codes that drive the EX-stage operand `data_mux_3` instances. It also raises the load-use stall toward the IF/ID pipeline registers. It sits beside the ID/EX register and consumes the destination already resolved by the ID-stage register mux, so `$ra` for link instructions is already applied.

## Interface
- `REG_BITS`, 5: register-index width.
- `CNT_W`, 16: stall-counter width.
- `clk` in 1: single pipeline clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID holds a real instruction, not a bubble.
- `id_rs`, `id_rt` in REG_BITS: source registers read by the ID instruction.
- `id_dst` in REG_BITS: resolved destination of the ID instruction.
- `id_we` in 1: the ID instruction writes `id_dst`.
- `id_load` in 1: the ID instruction is a load.
- `flush` in 1: taken branch or jump; squash the ID instruction.
- `stall` out 1: combinational load-use stall; holds PC and IF/ID.
- `fwd_a_sel`, `fwd_b_sel` out 2: registered EX operand selects. 0 = register-file value, 1 = EX/MEM ALU result, 2 = MEM/WB write-back data. 3 is never driven.
- `stall_count` out CNT_W: saturating count of stall cycles.

## Operation
- Internal tracking slots are `ex`, `mem` and `wb`. Each slot holds {valid, dst, we, load}.
- `hit(slot, r)` is true when slot.valid, slot.we, slot.dst == r, and r != 0. Register 0 never forwards.
- `stall` = id_valid & !flush & ex.load & (hit(ex, id_rs) | hit(ex, id_rt)).
- Select for source r, computed in ID:
  - hit(ex, r) gives 1, because the producer will be in MEM while the consumer is in EX.
  - Otherwise hit(mem, r) gives 2.
  - Otherwise 0. The register file is write-before-read, so a WB-slot producer needs no forward.
  - The ex slot wins over the mem slot, so the newest producer takes priority.
- Slot advance every cycle that is not in reset:
  - mem <= ex, and wb <= mem.
  - ex <= ID fields when id_valid & !stall & !flush. Otherwise ex <= bubble (valid = 0).
  - fwd_a_sel and fwd_b_sel load the computed selects when ex loads a real instruction. Otherwise they load 0.
- `stall_count` increments on every cycle with stall = 1 and saturates at all-ones.

## Timing
- Reset: all slot valid bits are 0, fwd_a_sel = fwd_b_sel = 0, stall_count = 0. stall reads 0 in the cycle after reset because the slots are empty.
- Select latency is one cycle: the selects are computed in the cycle the consumer is in ID and are valid through the consumer's EX cycle.
- Load-use costs exactly one stall cycle.
  - In the stall cycle the ID instruction is held by the upstream enables and a bubble enters ex.
  - In the next cycle the load is in mem, so the re-evaluated select is 2 and stall = 0.
- If flush and a load-use condition occur together, flush wins: stall = 0, ex gets a bubble, and the counter does not increment.
- If id_valid = 0, ex gets a bubble, the selects are 0 and stall = 0.
- If rs == rt and both hit, both selects take the same value.
- rst asserted mid-stream clears all slots on that edge. No forward or stall may reference pre-reset instructions afterward.
- At saturation, stall_count holds its value and does not wrap.

## Structure
- Select encodings (`FWD_RF` = 0, `FWD_EXMEM` = 1, `FWD_MEMWB` = 2) go in the shared `constants.v` next to `WORD`, so the datapath mux instances and this block agree.
- A single sub-module, `fwd_match`, handles the comparison. Inputs are ex and mem slot fields plus one source register; the output is a 2-bit select. It is instantiated twice, once for rs and once for rt.
- The slot registers and the counter stay in `fwd_unit`.

## Test plan
- `add $3,..` followed immediately by `add $4,$3,$5` -> in the consumer's EX cycle fwd_a_sel = 1, fwd_b_sel = 0, stall never 1.
- Producer of `$3`, one unrelated instruction, then a consumer of `$3` in rt -> fwd_b_sel = 2.
- `lw $8` followed by `add $9,$8,$8` -> stall = 1 for exactly one cycle, then fwd_a_sel = fwd_b_sel = 2, and stall_count = 1.
- Writes to `$0` followed by reads of `$0` -> selects stay 0 and no stall. Separately, `$7` written in back-to-back instructions and then read -> select 1 (newest producer).
- A load-use pair with flush asserted in the consumer's ID cycle -> stall = 0, ex bubble, and the next instruction's selects are unaffected by the squashed one.
- Forced stall count of 2^CNT_W−1 plus another stall -> the count holds. Reset pulsed mid-sequence -> selects 0 and stall 0 on the following cycle.

Source files
------------

// File: rtl/fwd_unit_pkg.sv
// Shared definitions for the EX-stage operand forwarding controller.
// Select encodings agree with the datapath data_mux_3 instances.
package fwd_unit_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/fwd_match.sv
// Source-register match against the ex and mem slots.
// Produces the forwarding select; the newest producer (ex) wins.
module fwd_match
  import fwd_unit_pkg::*;
#(
  parameter int REG_BITS = 5
) (
  input  logic                i_ex_valid,
  input  logic                i_ex_we,
  input  logic [REG_BITS-1:0] i_ex_dst,
  input  logic                i_mem_valid,
  input  logic                i_mem_we,
  input  logic [REG_BITS-1:0] i_mem_dst,
  input  logic [REG_BITS-1:0] i_src,
  output fwd_sel_e            o_sel
);

  logic w_nz;
  logic w_hit_ex;
  logic w_hit_mem;

  assign w_nz      = |i_src;
  assign w_hit_ex  = i_ex_valid & i_ex_we
                   & (i_ex_dst == i_src) & w_nz;
  assign w_hit_mem = i_mem_valid & i_mem_we
                   & (i_mem_dst == i_src) & w_nz;

  always_comb begin
    o_sel = FWD_RF;
    if (w_hit_ex)
      o_sel = FWD_EXMEM;
    else if (w_hit_mem)
      o_sel = FWD_MEMWB;
  end

endmodule

// File: rtl/fwd_unit.sv
// Forwarding and load-use hazard controller beside the ID/EX register.
// Tracks in-flight destinations and registers EX operand selects.
module fwd_unit
  import fwd_unit_pkg::*;
#(
  parameter int REG_BITS = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic [REG_BITS-1:0] id_dst,
  input  logic                id_we,
  input  logic                id_load,
  input  logic                flush,
  output logic                stall,
  output logic [1:0]          fwd_a_sel,
  output logic [1:0]          fwd_b_sel,
  output logic [CNT_W-1:0]    stall_count
);

  // The register file writes before it reads, so a producer past mem
  // never needs a forward and the wb slot carries no state here.
  logic                r_ex_valid;
  logic                r_ex_we;
  logic                r_ex_load;
  logic [REG_BITS-1:0] r_ex_dst;
  logic                r_mem_valid;
  logic                r_mem_we;
  logic [REG_BITS-1:0] r_mem_dst;
  fwd_sel_e            r_sel_a;
  fwd_sel_e            r_sel_b;
  logic [CNT_W-1:0]    r_cnt;

  fwd_sel_e            w_sel_a;
  fwd_sel_e            w_sel_b;
  logic                w_ex_hit;
  logic                w_stall;
  logic                w_issue;

  fwd_match #(.REG_BITS(REG_BITS)) u_match_rs (
    .i_ex_valid  (r_ex_valid),
    .i_ex_we     (r_ex_we),
    .i_ex_dst    (r_ex_dst),
    .i_mem_valid (r_mem_valid),
    .i_mem_we    (r_mem_we),
    .i_mem_dst   (r_mem_dst),
    .i_src       (id_rs),
    .o_sel       (w_sel_a)
  );

  fwd_match #(.REG_BITS(REG_BITS)) u_match_rt (
    .i_ex_valid  (r_ex_valid),
    .i_ex_we     (r_ex_we),
    .i_ex_dst    (r_ex_dst),
    .i_mem_valid (r_mem_valid),
    .i_mem_we    (r_mem_we),
    .i_mem_dst   (r_mem_dst),
    .i_src       (id_rt),
    .o_sel       (w_sel_b)
  );

  // An EXMEM select is exactly a hit on the ex slot.
  assign w_ex_hit = (w_sel_a == FWD_EXMEM)
                  | (w_sel_b == FWD_EXMEM);
  assign w_stall  = id_valid & ~flush
                  & r_ex_load & w_ex_hit;
  assign w_issue  = id_valid & ~w_stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid  <= 1'b0;
      r_ex_we     <= 1'b0;
      r_ex_load   <= 1'b0;
      r_ex_dst    <= '0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_dst   <= '0;
      r_sel_a     <= FWD_RF;
      r_sel_b     <= FWD_RF;
      r_cnt       <= '0;
    end else begin
      r_mem_valid <= r_ex_valid;
      r_mem_we    <= r_ex_we;
      r_mem_dst   <= r_ex_dst;
      r_ex_valid  <= w_issue;
      r_ex_we     <= id_we;
      r_ex_load   <= id_load;
      r_ex_dst    <= id_dst;
      r_sel_a     <= w_issue ? w_sel_a : FWD_RF;
      r_sel_b     <= w_issue ? w_sel_b : FWD_RF;
      if (w_stall && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign stall       = w_stall;
  assign fwd_a_sel   = r_sel_a;
  assign fwd_b_sel   = r_sel_b;
  assign stall_count = r_cnt;

endmodule

// File: tb/tb_fwd_unit.sv
// Scoreboard bench for fwd_unit: directed hazard cases plus random traffic
// against a reference model of in-flight producers.
module tb_fwd_unit;

  localparam int RB = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [RB-1:0] id_rs, id_rt, id_dst;
  logic          id_we, id_load, flush;
  logic          stall;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_count;

  fwd_unit #(.REG_BITS(RB), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_dst      (id_dst),
    .id_we       (id_we),
    .id_load     (id_load),
    .flush       (flush),
    .stall       (stall),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic [RB-1:0] d;
    logic          we;
    logic          ld;
  } instr_t;

  typedef struct packed {
    logic [1:0]    a;
    logic [1:0]    b;
    logic [CW-1:0] cnt;
  } exp_t;

  // flight[0] = entered EX last cycle (newest), flight[1] = one older
  instr_t flight [2];
  int     m_cnt;

  logic   q_stall [$];
  exp_t   q_post  [$];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [1:0] model_sel(logic [RB-1:0] r);
    for (int age = 0; age < 2; age++)
      if (r != 0 && flight[age].v && flight[age].we
          && flight[age].d == r)
        return (age == 0) ? 2'd1 : 2'd2;
    return 2'd0;
  endfunction

  function automatic logic model_stall(logic v, logic fl,
                                       logic [RB-1:0] rs,
                                       logic [RB-1:0] rt);
    logic dep;
    dep = (model_sel(rs) == 2'd1) || (model_sel(rt) == 2'd1);
    return v && !fl && flight[0].ld && dep;
  endfunction

  task automatic drive(input logic v, input logic [RB-1:0] rs,
                       input logic [RB-1:0] rt, input logic [RB-1:0] d,
                       input logic we, input logic ld,
                       input logic fl, input logic r);
    logic   st;
    logic   issue;
    exp_t   e;
    instr_t nw;
    @(negedge clk);
    id_valid = v; id_rs = rs; id_rt = rt; id_dst = d;
    id_we = we; id_load = ld; flush = fl; rst = r;
    st    = model_stall(v, fl, rs, rt);
    issue = v && !st && !fl;
    q_stall.push_back(st);
    nw = '{v: issue, d: d, we: we, ld: ld};
    if (r) begin
      flight[0] = '0;
      flight[1] = '0;
      m_cnt     = 0;
      e         = '{a: 2'd0, b: 2'd0, cnt: '0};
    end else begin
      e.a = issue ? model_sel(rs) : 2'd0;
      e.b = issue ? model_sel(rt) : 2'd0;
      if (st && m_cnt < (1 << CW) - 1)
        m_cnt++;
      e.cnt = CW'(m_cnt);
      flight[1] = flight[0];
      flight[0] = nw;
    end
    q_post.push_back(e);
  endtask

  task automatic nop();
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string nm, input int got, input int want);
    n_checks++;
    if (got == want)
      n_pass++;
    else
      $display("FAIL %s: got %0d want %0d at %0t", nm, got, want, $time);
  endtask

  // Combinational stall sampled mid low-phase, after inputs settle
  always @(negedge clk) begin
    #3;
    if (q_stall.size() != 0)
      check("stall", int'(stall), int'(q_stall.pop_front()));
  end

  // Registered outputs sampled just after the active edge
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (q_post.size() != 0) begin
      e = q_post.pop_front();
      check("fwd_a_sel", int'(fwd_a_sel), int'(e.a));
      check("fwd_b_sel", int'(fwd_b_sel), int'(e.b));
      check("stall_count", int'(stall_count), int'(e.cnt));
    end
  end

  initial begin
    flight[0] = '0;
    flight[1] = '0;
    m_cnt = 0;
    rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0;
    id_dst = '0; id_we = 1'b0; id_load = 1'b0; flush = 1'b0;

    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    nop();

    // add $3 ; add $4,$3,$5
    drive(1, 1, 2, 3, 1, 0, 0, 0);
    drive(1, 3, 5, 4, 1, 0, 0, 0);
    nop(); nop();

    // producer $3, unrelated, consumer $3 in rt
    drive(1, 1, 2, 3, 1, 0, 0, 0);
    drive(1, 10, 11, 12, 1, 0, 0, 0);
    drive(1, 6, 3, 13, 1, 0, 0, 0);
    nop(); nop();

    // lw $8 ; add $9,$8,$8 held one cycle
    drive(1, 1, 0, 8, 1, 1, 0, 0);
    drive(1, 8, 8, 9, 1, 0, 0, 0);
    drive(1, 8, 8, 9, 1, 0, 0, 0);
    nop(); nop();

    // writes to $0 then reads of $0
    drive(1, 1, 2, 0, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 5, 1, 0, 0, 0);
    nop(); nop();

    // $7 written back-to-back, then read
    drive(1, 1, 2, 7, 1, 0, 0, 0);
    drive(1, 1, 2, 7, 1, 0, 0, 0);
    drive(1, 7, 7, 14, 1, 0, 0, 0);
    nop(); nop();

    // load-use with flush in consumer's ID, then unrelated-by-squash reader
    drive(1, 1, 2, 8, 1, 1, 0, 0);
    drive(1, 8, 2, 9, 1, 0, 1, 0);
    drive(1, 9, 8, 15, 1, 0, 0, 0);
    nop(); nop();

    // saturate the stall counter with repeated load-use pairs
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 2, 8, 1, 1, 0, 0);
      drive(1, 8, 3, 9, 1, 0, 0, 0);
      drive(1, 8, 3, 9, 1, 0, 0, 0);
    end

    // reset mid-stream right behind a load
    drive(1, 1, 2, 8, 1, 1, 0, 0);
    drive(1, 8, 8, 9, 1, 0, 0, 1);
    drive(1, 8, 8, 9, 1, 0, 0, 0);
    nop(); nop();

    // random traffic over a narrow register range
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(99) < 85) ? 1'b1 : 1'b0,
            RB'($urandom_range(3)), RB'($urandom_range(3)),
            RB'($urandom_range(3)),
            ($urandom_range(99) < 80) ? 1'b1 : 1'b0,
            ($urandom_range(99) < 35) ? 1'b1 : 1'b0,
            ($urandom_range(99) < 10) ? 1'b1 : 1'b0,
            ($urandom_range(99) < 2)  ? 1'b1 : 1'b0);
    end

    nop();
    repeat (4) @(negedge clk);
    check("drained", q_stall.size() + q_post.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
